// File: rtl/adder_tree_pipe.sv
// adder_tree_pipe: fully pipelined unsigned N_IN-operand adder tree, one register per level plus an output register.
// Define ADDER_TREE_ACC_EN to compile in the ACC_LEN-sample window accumulator; otherwise acc_mode/clr are ignored.
module adder_tree_pipe #(
   parameter int IN_W    = 14,
   parameter int N_IN    = 4,
   parameter int ACC_LEN = 4
) (
   input  logic                                              clk,
   input  logic                                              rst,
   input  logic                                              in_valid,
   input  logic [N_IN*IN_W-1:0]                              in_data,
   input  logic                                              acc_mode,
   input  logic                                              clr,
   output logic                                              out_valid,
   output logic [IN_W+$clog2(N_IN)+$clog2(ACC_LEN)-1:0]      out_data
);

   localparam int LVL   = $clog2(N_IN);
   localparam int SUM_W = IN_W + LVL;
   localparam int ACC_W = $clog2(ACC_LEN);
   localparam int OUT_W = SUM_W + ACC_W;

   // All tree levels share one flat bus; level j holds N_IN>>j nodes of IN_W+j bits each.
   function automatic int lvl_off(input int j);
      int off;
      off = 0;
      for (int i = 0; i < j; i++) begin
         off = off + (N_IN >> i) * (IN_W + i);
      end
      return off;
   endfunction

   localparam int TOT_W = lvl_off(LVL + 1);

   logic [TOT_W-1:0] tree_s;
   logic [LVL:0]     vld_s;
   logic [SUM_W-1:0] sum_s;
   logic             sum_v_s;

   logic             out_valid_q, out_valid_d;
   logic [OUT_W-1:0] out_data_q,  out_data_d;

   assign tree_s[N_IN*IN_W-1:0] = in_data;
   assign vld_s[0]              = in_valid;

   for (genvar j = 1; j <= LVL; j++) begin : g_lvl
      localparam int W    = IN_W + j;
      localparam int PW   = W - 1;
      localparam int NN   = N_IN >> j;
      localparam int OFF  = lvl_off(j);
      localparam int POFF = lvl_off(j - 1);

      logic [NN*W-1:0] data_d;
      logic [NN*W-1:0] data_q;
      logic            vld_q;

      for (genvar k = 0; k < NN; k++) begin : g_node
         assign data_d[k*W +: W] = {1'b0, tree_s[POFF + (2*k)*PW +: PW]}
                                 + {1'b0, tree_s[POFF + (2*k+1)*PW +: PW]};
      end

      // Level register: data only advances with a valid sample, so idle cycles leave it untouched.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            data_q <= '0;
            vld_q  <= 1'b0;
         end else begin
            vld_q <= vld_s[j-1];
            if (vld_s[j-1]) begin
               data_q <= data_d;
            end else begin
               data_q <= data_q;
            end
         end
      end

      assign tree_s[OFF +: NN*W] = data_q;
      assign vld_s[j]            = vld_q;
   end

   assign sum_s   = tree_s[lvl_off(LVL) +: SUM_W];
   assign sum_v_s = vld_s[LVL];

`ifdef ADDER_TREE_ACC_EN
   localparam int CNT_W = (ACC_W > 0) ? ACC_W : 1;

   logic [OUT_W-1:0] acc_q, acc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             mode_q;
   logic             restart_s;
   logic [OUT_W-1:0] acc_sum_s;

   assign restart_s = clr | (acc_mode ^ mode_q);
   assign acc_sum_s = acc_q + OUT_W'(sum_s);

   // Output stage: per-sample pass-through or window accumulation; a restart lets the arriving sample open the new window.
   always_comb begin
      out_valid_d = 1'b0;
      out_data_d  = out_data_q;
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      if (!acc_mode || (ACC_LEN == 1)) begin
         acc_d = '0;
         cnt_d = '0;
         if (sum_v_s) begin
            out_valid_d = 1'b1;
            out_data_d  = OUT_W'(sum_s);
         end else begin
            out_valid_d = 1'b0;
            out_data_d  = out_data_q;
         end
      end else if (restart_s) begin
         if (sum_v_s) begin
            acc_d = OUT_W'(sum_s);
            cnt_d = CNT_W'(1);
         end else begin
            acc_d = '0;
            cnt_d = '0;
         end
      end else if (sum_v_s) begin
         if (cnt_q == CNT_W'(ACC_LEN - 1)) begin
            out_valid_d = 1'b1;
            out_data_d  = acc_sum_s;
            acc_d       = '0;
            cnt_d       = '0;
         end else begin
            acc_d = acc_sum_s;
            cnt_d = cnt_q + CNT_W'(1);
         end
      end else begin
         acc_d = acc_q;
         cnt_d = cnt_q;
      end
   end

   // Accumulator state and the registered mode used to detect mode switches.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_q  <= '0;
         cnt_q  <= '0;
         mode_q <= 1'b0;
      end else begin
         acc_q  <= acc_d;
         cnt_q  <= cnt_d;
         mode_q <= acc_mode;
      end
   end
`else
   logic unused_ctrl_s;
   assign unused_ctrl_s = acc_mode ^ clr;

   // Output stage without accumulator: every tree sum is emitted zero-extended.
   always_comb begin
      out_valid_d = 1'b0;
      out_data_d  = out_data_q;
      if (sum_v_s) begin
         out_valid_d = 1'b1;
         out_data_d  = OUT_W'(sum_s);
      end else begin
         out_valid_d = 1'b0;
         out_data_d  = out_data_q;
      end
   end
`endif

   // Output register; out_data holds its last value between pulses.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;

endmodule
